// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage load/store controller driving a req/gnt/rvalid data bus
module mem_access_ctrl #(
    parameter int WORD_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memRead_ex,
    input  logic                  memWrite_ex,
    input  logic [2:0]            funct_ex,
    input  logic [WORD_WIDTH-1:0] alu_result,
    input  logic [WORD_WIDTH-1:0] rd_data2_ex,
    output logic                  stall,
    output logic [WORD_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  misaligned,
    output logic                  bus_err,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [WORD_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [WORD_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [WORD_WIDTH-1:0] dmem_rdata
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [2:0]              funct_q;
    logic [1:0]              off_q;
    logic                    access, is_b, is_h, mis, done_ok, tmo;
    logic [3:0]              be_c;
    logic [WORD_WIDTH-1:0]   wdata_c, ext;
    logic [7:0]              byte_v;
    logic [15:0]             half_v;
    always_comb begin
        access  = memRead_ex | memWrite_ex;
        is_b    = funct_ex[1:0] == 2'b00;
        is_h    = funct_ex[1:0] == 2'b01;
        mis     = is_b ? 1'b0 : is_h ? alu_result[0] : |alu_result[1:0];
        be_c    = is_b ? 4'b0001 << alu_result[1:0] : is_h ? 4'b0011 << {alu_result[1], 1'b0} : 4'b1111;
        wdata_c = is_b ? {4{rd_data2_ex[7:0]}} : is_h ? {2{rd_data2_ex[15:0]}} : rd_data2_ex;
        byte_v  = 8'(dmem_rdata >> {off_q, 3'b000});
        half_v  = 16'(dmem_rdata >> {off_q[1], 4'b0000});
        ext     = funct_q[1:0] == 2'b00 ? {{24{~funct_q[2] & byte_v[7]}}, byte_v} :
                  funct_q[1:0] == 2'b01 ? {{16{~funct_q[2] & half_v[15]}}, half_v} : dmem_rdata;
        done_ok = (state == REQ && dmem_gnt && (dmem_we || dmem_rvalid)) || (state == WAIT && dmem_rvalid);
        tmo     = (state == REQ || state == WAIT) && !done_ok && cnt == CW'(TIMEOUT - 1);
        stall      = (state == IDLE && access && !mis) || state == REQ || state == WAIT;
        misaligned = state == IDLE && access && mis;
        dmem_req   = state == REQ;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            funct_q    <= '0;
            off_q      <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            bus_err    <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
        end else begin
            load_valid <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: if (access && !mis) begin
                    state      <= REQ;
                    cnt        <= '0;
                    funct_q    <= funct_ex;
                    off_q      <= alu_result[1:0];
                    dmem_we    <= memWrite_ex;
                    dmem_addr  <= {alu_result[WORD_WIDTH-1:2], 2'b00};
                    dmem_be    <= be_c;
                    dmem_wdata <= wdata_c;
                end
                REQ, WAIT: begin
                    if (done_ok) begin
                        state <= DONE;
                        if (!dmem_we) begin
                            load_data  <= ext;
                            load_valid <= 1'b1;
                        end
                    end else if (tmo) begin
                        state     <= DONE;
                        bus_err   <= 1'b1;
                        load_data <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (state == REQ && dmem_gnt) state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized self-checking bench with a behavioural memory-access model
module tb_mem_access_ctrl;
    localparam int TIMEOUT = 16;
    logic        clk = 0, rst = 1;
    logic        memRead_ex = 0, memWrite_ex = 0;
    logic [2:0]  funct_ex = 0;
    logic [31:0] alu_result = 0, rd_data2_ex = 0;
    logic        stall, load_valid, misaligned, bus_err, dmem_req, dmem_we;
    logic [31:0] load_data, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 0, dmem_rvalid = 0;
    logic [31:0] dmem_rdata = 0;
    int checks = 0, failures = 0;
    int o_stall, o_req;
    logic o_lv, o_berr, o_mis, o_stable, o_done, o_we;
    logic [31:0] o_ld, o_addr, o_wd;
    logic [3:0] o_be;

    mem_access_ctrl #(.WORD_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .memRead_ex(memRead_ex), .memWrite_ex(memWrite_ex),
        .funct_ex(funct_ex), .alu_result(alu_result), .rd_data2_ex(rd_data2_ex),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .misaligned(misaligned), .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata));

    always #5 clk = ~clk;

    function automatic int acc_size(input logic [2:0] f);
        return (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : 4;
    endfunction
    function automatic logic exp_mis(input logic [2:0] f, input logic [31:0] a);
        return (a % acc_size(f)) != 0;
    endfunction
    function automatic logic [3:0] exp_be(input logic [2:0] f, input logic [31:0] a);
        int s = acc_size(f);
        return 4'(((1 << s) - 1) << (a % 4));
    endfunction
    function automatic logic [31:0] exp_wdata(input logic [2:0] f, input logic [31:0] d);
        logic [31:0] w;
        int s = acc_size(f);
        for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % s) +: 8];
        return w;
    endfunction
    function automatic logic [31:0] exp_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] r);
        int s = acc_size(f);
        longint v = (longint'(r) >> (8 * (a % 4))) & ((longint'(1) << (8 * s)) - 1);
        if (s < 4 && f < 3'd4 && v >= (longint'(1) << (8 * s - 1))) v -= longint'(1) << (8 * s);
        return 32'(v);
    endfunction

    // Drives one access and a simple memory responder; records what the DUT did.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] d, input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        int rc = 0, wc = 0;
        logic granted = 0;
        o_stall = 0; o_req = 0; o_lv = 0; o_berr = 0; o_mis = 0; o_stable = 1; o_done = 0;
        o_ld = 0; o_addr = 0; o_wd = 0; o_be = 0; o_we = 0;
        memRead_ex = rd; memWrite_ex = wr; funct_ex = f; alu_result = a; rd_data2_ex = d;
        dmem_rdata = rdata;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (stall) o_stall++;
            if (misaligned) o_mis = 1;
            if (bus_err) o_berr = 1;
            if (load_valid) o_lv = 1;
            if (dmem_req) begin
                if (o_req == 0) begin
                    o_addr = dmem_addr; o_be = dmem_be; o_wd = dmem_wdata; o_we = dmem_we;
                end else if (o_addr !== dmem_addr || o_be !== dmem_be || o_wd !== dmem_wdata || o_we !== dmem_we)
                    o_stable = 0;
                o_req++;
            end
            if (!stall) begin
                o_ld = load_data;
                o_done = 1;
                break;
            end
            dmem_gnt = 0; dmem_rvalid = 0;
            if (dmem_req) begin
                if (rc == gnt_dly) begin
                    dmem_gnt = 1; granted = 1; wc = 0;
                    dmem_rvalid = rv_dly == 0;
                end
                rc++;
            end else if (granted) begin
                wc++;
                dmem_rvalid = wc == rv_dly;
            end
        end
        memRead_ex = 0; memWrite_ex = 0; dmem_gnt = 0; dmem_rvalid = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({stall, load_valid, misaligned, bus_err, dmem_req, dmem_we, dmem_be, load_data, dmem_addr, dmem_wdata} !== '0) begin
            failures++; $display("FAIL reset_outputs got stall=%b req=%b lv=%b be=%h", stall, dmem_req, load_valid, dmem_be);
        end
        @(posedge clk); #1; rst = 0;
    endtask

    task automatic test_lw;
        run_access(1, 0, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF);
        checks++; if (o_stall !== 2) begin failures++; $display("FAIL lw_stall got %0d exp 2", o_stall); end
        checks++; if (o_lv !== 1 || o_ld !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got lv=%b %h exp 1 deadbeef", o_lv, o_ld); end
        checks++; if (o_be !== 4'hF || o_addr !== 32'h100 || o_we !== 0) begin failures++; $display("FAIL lw_bus got be=%b addr=%h we=%b", o_be, o_addr, o_we); end
    endtask

    task automatic test_lb;
        run_access(1, 0, 3'b000, 32'h103, 0, 0, 0, 32'h80FF_0000);
        checks++; if (o_be !== 4'b1000 || o_ld !== 32'hFFFFFF80 || o_addr !== 32'h100) begin
            failures++; $display("FAIL lb got be=%b ld=%h addr=%h exp 1000 ffffff80 100", o_be, o_ld, o_addr); end
        run_access(1, 0, 3'b100, 32'h103, 0, 0, 0, 32'h80FF_0000);
        checks++; if (o_ld !== 32'h00000080) begin failures++; $display("FAIL lbu got %h exp 00000080", o_ld); end
    endtask

    task automatic test_sh_delayed;
        run_access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 3, 0, 0);
        checks++; if (o_be !== 4'b1100 || o_wd !== 32'hABCDABCD || o_we !== 1 || o_addr !== 32'h200) begin
            failures++; $display("FAIL sh_bus got be=%b wd=%h we=%b addr=%h", o_be, o_wd, o_we, o_addr); end
        checks++; if (o_req !== 4 || o_stable !== 1) begin failures++; $display("FAIL sh_req got cycles=%0d stable=%b exp 4 1", o_req, o_stable); end
        checks++; if (o_stall !== 5 || o_lv !== 0 || o_done !== 1) begin failures++; $display("FAIL sh_stall got %0d lv=%b done=%b exp 5 0 1", o_stall, o_lv, o_done); end
    endtask

    task automatic test_misaligned;
        run_access(1, 0, 3'b010, 32'h101, 0, 0, 0, 0);
        checks++; if (o_mis !== 1 || o_req !== 0 || o_stall !== 0) begin
            failures++; $display("FAIL misaligned got mis=%b req=%0d stall=%0d exp 1 0 0", o_mis, o_req, o_stall); end
        @(negedge clk);
        checks++; if (misaligned !== 0 || dmem_req !== 0) begin failures++; $display("FAIL misaligned_pulse got mis=%b req=%b", misaligned, dmem_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout;
        run_access(1, 0, 3'b010, 32'h40, 0, 0, -1, 32'h5555AAAA);
        checks++; if (o_berr !== 1 || o_lv !== 0 || o_ld !== 0 || o_done !== 1) begin
            failures++; $display("FAIL timeout_wait got berr=%b lv=%b ld=%h done=%b", o_berr, o_lv, o_ld, o_done); end
        checks++; if (o_stall !== TIMEOUT + 1) begin failures++; $display("FAIL timeout_len got %0d exp %0d", o_stall, TIMEOUT + 1); end
        run_access(0, 1, 3'b010, 32'h44, 32'h1, 99, 0, 0);
        checks++; if (o_berr !== 1 || o_req !== TIMEOUT) begin failures++; $display("FAIL timeout_nogrant got berr=%b req=%0d", o_berr, o_req); end
        run_access(1, 0, 3'b010, 32'h48, 0, 0, TIMEOUT - 1, 32'h0BADF00D);
        checks++; if (o_berr !== 0 || o_lv !== 1 || o_ld !== 32'h0BADF00D) begin
            failures++; $display("FAIL timeout_lastcycle got berr=%b lv=%b ld=%h exp 0 1 0badf00d", o_berr, o_lv, o_ld); end
    endtask

    task automatic test_reset_mid;
        memRead_ex = 1; funct_ex = 3'b010; alu_result = 32'h80;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk); dmem_gnt = 1;
        @(posedge clk); #1; dmem_gnt = 0;
        @(posedge clk); #1; rst = 1; memRead_ex = 0;
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        checks++; if ({stall, load_valid, bus_err, dmem_req, dmem_we, dmem_be, load_data, dmem_addr, dmem_wdata} !== '0) begin
            failures++; $display("FAIL reset_mid got stall=%b req=%b be=%h addr=%h", stall, dmem_req, dmem_be, dmem_addr); end
        dmem_rvalid = 1; dmem_rdata = 32'h12345678;
        @(posedge clk); #1; dmem_rvalid = 0;
        @(negedge clk);
        checks++; if (load_valid !== 0 || stall !== 0 || load_data !== 0) begin
            failures++; $display("FAIL reset_stale_rvalid got lv=%b stall=%b ld=%h", load_valid, stall, load_data); end
        @(posedge clk); #1;
        run_access(1, 0, 3'b010, 32'h84, 0, 1, 1, 32'hCAFEF00D);
        checks++; if (o_lv !== 1 || o_ld !== 32'hCAFEF00D || o_stall !== 4) begin
            failures++; $display("FAIL reset_recover got lv=%b ld=%h stall=%0d", o_lv, o_ld, o_stall); end
    endtask

    task automatic test_back_to_back;
        run_access(0, 1, 3'b000, 32'h301, 32'h000000A5, 0, 0, 0);
        run_access(1, 0, 3'b101, 32'h302, 0, 0, 0, 32'h8001_1234);
        checks++; if (o_stall !== 2 || o_ld !== 32'h00008001 || o_be !== 4'b1100) begin
            failures++; $display("FAIL back_to_back got stall=%0d ld=%h be=%b", o_stall, o_ld, o_be); end
    endtask

    task automatic test_random;
        logic [2:0] fs [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int n = 0; n < 60; n++) begin
            logic rd, wr, ld;
            logic [2:0] f = fs[$urandom_range(7)];
            logic [31:0] a = $urandom, d = $urandom, r = $urandom;
            int g = $urandom_range(3), v = $urandom_range(3);
            int exp_st;
            wr = $urandom_range(1);
            rd = wr ? 1'($urandom_range(1)) : 1'b1;
            if ($urandom_range(1)) a[1:0] = 2'b00;
            ld = !wr;
            exp_st = 2 + g + (ld ? v : 0);
            run_access(rd, wr, f, a, d, g, v, r);
            if (exp_mis(f, a)) begin
                checks++; if (o_mis !== 1 || o_req !== 0 || o_stall !== 0) begin
                    failures++; $display("FAIL rnd_mis n=%0d f=%0d a=%h got mis=%b req=%0d", n, f, a, o_mis, o_req); end
            end else begin
                checks++; if (o_mis !== 0 || o_be !== exp_be(f, a) || o_addr !== {a[31:2], 2'b00} || o_we !== wr || o_stall !== exp_st) begin
                    failures++; $display("FAIL rnd_bus n=%0d f=%0d a=%h got be=%b addr=%h we=%b st=%0d exp be=%b st=%0d",
                                         n, f, a, o_be, o_addr, o_we, o_stall, exp_be(f, a), exp_st); end
                checks++; if (wr ? (o_wd !== exp_wdata(f, d) || o_lv !== 0) : (o_lv !== 1 || o_ld !== exp_load(f, a, r))) begin
                    failures++; $display("FAIL rnd_data n=%0d f=%0d a=%h wr=%b got wd=%h ld=%h lv=%b exp wd=%h ld=%h",
                                         n, f, a, wr, o_wd, o_ld, o_lv, exp_wdata(f, d), exp_load(f, a, r)); end
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_lw;
        test_lb;
        test_sh_delayed;
        test_misaligned;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
